// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide for the EX stage, RISC-V M semantics.
// Optional MULDIV_ZERO_BYPASS_EN: zero-operand MUL and zero-dividend DIVU/REMU finish in one cycle.
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1Data_in,
  input  logic [XLEN-1:0] rs2Data_in,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;       // multiplicand, or divisor magnitude
  logic [XLEN-1:0]   b_q, b_d;       // multiplier, or dividend shifting into quotient
  logic [XLEN-1:0]   acc_q, acc_d;   // product accumulator, or partial remainder
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   rs1_mag;
  logic [XLEN-1:0]   rs2_mag;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;

  // Single-cycle cases, resolved from the raw request operands.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
`ifdef MULDIV_ZERO_BYPASS_EN
    if ((op == OP_MUL && (rs1Data_in == '0 || rs2Data_in == '0)) ||
        ((op == OP_DIVU || op == OP_REMU) && rs1Data_in == '0)) begin
      special     = 1'b1;
      special_res = '0;
    end
`endif
    // Divide-by-zero outranks the zero-dividend bypass (DIVU 0/0 must be all ones).
    if (op != OP_MUL && rs2Data_in == '0) begin
      special     = 1'b1;
      special_res = (op == OP_REMU) ? rs1Data_in : ALL_ONES;
    end else if (op == OP_DIV && rs1Data_in == MOST_NEG && rs2Data_in == ALL_ONES) begin
      special     = 1'b1;
      special_res = rs1Data_in;
    end
  end

  always_comb begin
    rs1_mag = (op == OP_DIV && rs1Data_in[XLEN-1]) ? (~rs1Data_in + 1'b1) : rs1Data_in;
    rs2_mag = (op == OP_DIV && rs2Data_in[XLEN-1]) ? (~rs2Data_in + 1'b1) : rs2Data_in;
  end

  // Restoring-divide step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    rem_shift = {acc_q, b_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, a_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          rd_d  = rd_in;
          op_d  = op;
          cnt_d = '0;
          acc_d = '0;
          neg_d = (op == OP_DIV) && (rs1Data_in[XLEN-1] ^ rs2Data_in[XLEN-1]);
          if (op == OP_MUL) begin
            a_d = rs1Data_in;
            b_d = rs2Data_in;
          end else begin
            a_d = rs2_mag;
            b_d = rs1_mag;
          end
          if (special) begin
            result_d = special_res;
            state_d  = FIN;
          end else begin
            state_d  = CALC;
          end
        end
      end

      CALC: begin
        if (cnt_q == LAST_CNT) begin
          // Result is published only on entry to FIN so consumers never see partials.
          unique case (op_q)
            OP_MUL:  result_d = acc_q;
            OP_DIV:  result_d = neg_q ? (~b_q + 1'b1) : b_q;
            OP_DIVU: result_d = b_q;
            default: result_d = acc_q;
          endcase
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q == OP_MUL) begin
            if (b_q[0]) begin
              acc_d = acc_q + a_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end else begin
            acc_d = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
            b_d   = {b_q[XLEN-2:0], ~rem_diff[XLEN]};
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed, table-driven bench for ex_muldiv_unit (XLEN=64) plus flush / reset / busy-start sequences.
module tb_ex_muldiv_unit;

  localparam int XLEN     = 64;
  localparam int NORM_LAT = XLEN + 1;
`ifdef MULDIV_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = NORM_LAT;
`endif

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .start      (start),
    .op         (op),
    .rs1Data_in (rs1),
    .rs2Data_in (rs2),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_out     (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic [XLEN-1:0] exp;
    int              lat;   // done visible after edge E0+lat (E0 = accept edge)
  } vec_t;

  vec_t vecs[14];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [XLEN-1:0] prev;
    int              lat;
    bit              busy_ok;
    bit              hold_ok;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    prev  = result;
    op    = v.op;
    rs1   = v.a;
    rs2   = v.b;
    rd_in = v.rd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    $display("vec %0d: op=%0d a=0x%h b=0x%h -> result=0x%h rd=%0d latency=%0d",
             idx, v.op, v.a, v.b, result, rd_out, lat);
    check($sformatf("vec%0d latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("vec%0d result", idx), result, v.exp);
    check($sformatf("vec%0d rd_out", idx), 64'(rd_out), 64'(v.rd));
    check($sformatf("vec%0d busy_with_done", idx), 64'(busy), 64'(1));
    check($sformatf("vec%0d busy_while_calc", idx), 64'(busy_ok), 64'(1));
    check($sformatf("vec%0d result_stable_calc", idx), 64'(hold_ok), 64'(1));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d done_one_cycle", idx), 64'(done), 64'(0));
    check($sformatf("vec%0d busy_after", idx), 64'(busy), 64'(0));
    check($sformatf("vec%0d result_held", idx), result, v.exp);
  endtask

  initial begin
    logic [XLEN-1:0] prev;
    int              lat;
    bit              done_seen;

    vecs[0]  = '{OP_MUL,  64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, NORM_LAT};
    vecs[1]  = '{OP_DIV,  64'hFFFF_FFFF_FFFF_FFEC, 64'h3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFA, NORM_LAT};
    vecs[2]  = '{OP_REMU, 64'd20, 64'd3, 5'd7, 64'd2, NORM_LAT};
    vecs[3]  = '{OP_DIVU, 64'h1234, 64'h0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[4]  = '{OP_REMU, 64'h1234, 64'h0, 5'd9, 64'h1234, 0};
    vecs[5]  = '{OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h8000_0000_0000_0000, 0};
    vecs[6]  = '{OP_DIVU, 64'd100, 64'd7, 5'd11, 64'd14, NORM_LAT};
    vecs[7]  = '{OP_DIV,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd12, 64'hFFFF_FFFF_FFFF_FFFA, NORM_LAT};
    vecs[8]  = '{OP_DIV,  64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFD, 5'd13, 64'd6, NORM_LAT};
    vecs[9]  = '{OP_MUL,  64'h1_0000_0000, 64'h1_0000_0001, 5'd14, 64'h1_0000_0000, NORM_LAT};
    vecs[10] = '{OP_MUL,  64'h0, 64'd5, 5'd15, 64'h0, ZERO_LAT};
    vecs[11] = '{OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd16, 64'hF, NORM_LAT};
    vecs[12] = '{OP_DIV,  64'h8000_0000_0000_0000, 64'd2, 5'd17, 64'hC000_0000_0000_0000, NORM_LAT};
    vecs[13] = '{OP_DIVU, 64'h0, 64'd5, 5'd31, 64'h0, ZERO_LAT};

    rst   = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    op    = '0;
    rs1   = '0;
    rs2   = '0;
    rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset result", result, 64'h0);
    check("reset rd_out", 64'(rd_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // Flush at iteration 10 together with a new start: op killed, new start dropped.
    @(negedge clk);
    prev  = result;
    op    = OP_MUL;
    rs1   = 64'd3;
    rs2   = 64'd5;
    rd_in = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    rs1   = 64'd9;
    rs2   = 64'd9;
    rd_in = 5'd7;
    @(posedge clk);
    #1;
    check("flush busy_next", 64'(busy), 64'(0));
    check("flush done_next", 64'(done), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1'b1;
    end
    $display("flush seq: rd_out=%0d result=0x%h activity=%0d", rd_out, result, done_seen);
    check("flush no_activity", 64'(done_seen), 64'(0));
    check("flush rd_out", 64'(rd_out), 64'(3));
    check("flush result_held", result, prev);

    // MUL 6x7 with a stray start mid-calculation that must be ignored.
    @(negedge clk);
    op    = OP_MUL;
    rs1   = 64'd6;
    rs2   = 64'd7;
    rd_in = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      if (lat == 5) begin
        op    = OP_DIVU;
        rs1   = 64'd99;
        rs2   = 64'd1;
        rd_in = 5'd20;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    $display("mul 6x7: result=%0d rd=%0d latency=%0d", result, rd_out, lat);
    check("mul42 latency", 64'(lat), 64'(NORM_LAT));
    check("mul42 result", result, 64'd42);
    check("mul42 rd_out", 64'(rd_out), 64'(9));
    @(posedge clk);
    #1;
    check("mul42 idle_after", 64'(busy), 64'(0));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    op    = OP_DIVU;
    rs1   = 64'd100;
    rs2   = 64'd7;
    rd_in = 5'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: busy=%0d done=%0d result=0x%h rd=%0d", busy, done, result, rd_out);
    check("arst busy", 64'(busy), 64'(0));
    check("arst done", 64'(done), 64'(0));
    check("arst result", result, 64'h0);
    check("arst rd_out", 64'(rd_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1'b1;
    end
    check("arst no_done", 64'(done_seen), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
